// File: rtl/predecode_pipe.sv
// predecode_pipe: one-stage handshaked predecode between ICache data return and IBuffer.
// Holds one fetch block, predecodes every 32-bit slot for jal/jalr/branch and RAS hints,
// checks the block against the FSQ prediction, raises a one-shot redirect on a
// mispredict, and forwards only the correct-path slots.
// Optional build macro: PREDECODE_FALSEHIT_EN enables the predictor false-hit check
// (predicted taken, but the tail slot is not a jump or branch).

package predecode_pkg;
   typedef enum logic [1:0] {
      BR_CONDITION = 2'd0,
      BR_DIRECT    = 2'd1,
      BR_INDIRECT  = 2'd2,
      BR_CALL      = 2'd3
   } branch_type_e;

   typedef enum logic [1:0] {
      RAS_NONE     = 2'd0,
      RAS_POP      = 2'd1,
      RAS_PUSH     = 2'd2,
      RAS_POP_PUSH = 2'd3
   } ras_type_e;
endpackage

module predecode_pipe
   import predecode_pkg::*;
#(
   parameter  int INST_NUM = 8,
   parameter  int VADDR_W  = 32,
   parameter  int FSQ_W    = 5,
   localparam int SW       = $clog2(INST_NUM)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_flush,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [INST_NUM-1:0]     i_in_en,
   input  logic [INST_NUM*32-1:0]  i_in_data,
   input  logic [VADDR_W-1:0]      i_in_start_addr,
   input  logic [SW-1:0]           i_in_tail,
   input  logic                    i_in_taken,
   input  logic [VADDR_W-1:0]      i_in_target,
   input  logic [FSQ_W-1:0]        i_in_fsq_idx,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [INST_NUM-1:0]     o_out_en,
   output logic [INST_NUM*32-1:0]  o_out_inst,
   output logic [SW:0]             o_out_num,
   output logic [FSQ_W-1:0]        o_out_fsq_idx,
   output logic                    o_rd_valid,
   output logic [FSQ_W-1:0]        o_rd_fsq_idx,
   output logic [SW-1:0]           o_rd_offset,
   output logic [VADDR_W-1:0]      o_rd_pc,
   output logic [VADDR_W-1:0]      o_rd_addr,
   output branch_type_e            o_rd_br_type,
   output ras_type_e               o_rd_ras_type
);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // S1 holding register
   logic                   r_valid;
   logic [INST_NUM-1:0]    r_en;
   logic [INST_NUM*32-1:0] r_data;
   logic [VADDR_W-1:0]     r_start_addr;
   logic [SW-1:0]          r_tail;
   logic                   r_taken;
   logic [VADDR_W-1:0]     r_target;
   logic [FSQ_W-1:0]       r_fsq_idx;

   // Per-slot predecode results
   logic [INST_NUM-1:0]    w_jal;
   logic [INST_NUM-1:0]    w_jalr;
   logic [INST_NUM-1:0]    w_br;
   logic [INST_NUM-1:0]    w_jmp;
   logic [VADDR_W-1:0]     w_tgt     [INST_NUM];
   branch_type_e           w_br_type [INST_NUM];
   ras_type_e              w_ras     [INST_NUM];

   logic                   w_any_jmp;
   logic [SW-1:0]          w_sel;
   logic                   w_mis;
   logic [SW-1:0]          w_off;
   logic [VADDR_W-1:0]     w_addr;
   branch_type_e           w_rd_br_type;
   ras_type_e              w_rd_ras_type;
   logic [INST_NUM-1:0]    w_out_en;
   logic [SW:0]            w_out_num;
   logic                   w_fire;
   logic                   w_in_ready;
   logic                   w_load;
`ifdef PREDECODE_FALSEHIT_EN
   logic [VADDR_W-1:0]     w_fall_addr;
   logic                   w_tail_is_cfi;
`endif

   // Handshake: a mispredicting block leaves alone, so no wrong-path block enters behind it
   assign w_fire     = r_valid && i_out_ready;
   assign w_in_ready = !i_flush && (!r_valid || (w_fire && !w_mis));
   assign w_load     = i_in_valid && w_in_ready;

   // S1 register: flush beats a same-cycle load; a block without successor empties on fire
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated only with non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      if (rst) begin
         r_valid      <= 1'b0;
         r_en         <= '0;
         r_data       <= '0;
         r_start_addr <= '0;
         r_tail       <= '0;
         r_taken      <= 1'b0;
         r_target     <= '0;
         r_fsq_idx    <= '0;
      end else begin
         if (i_flush) begin
            r_valid <= 1'b0;
         end else if (w_load) begin
            r_valid <= 1'b1;
         end else if (w_fire) begin
            r_valid <= 1'b0;
         end
         if (w_load) begin
            r_en         <= i_in_en;
            r_data       <= i_in_data;
            r_start_addr <= i_in_start_addr;
            r_tail       <= i_in_tail;
            r_taken      <= i_in_taken;
            r_target     <= i_in_target;
            r_fsq_idx    <= i_in_fsq_idx;
         end
      end
   end

   // Per-slot decode: instruction class, jal target, branch and RAS hint
   always_comb begin
      logic [31:0]        inst;
      logic [VADDR_W-1:0] pc;
      logic [VADDR_W-1:0] jimm;
      logic               push;
      logic               pop;
      // NOTE: every signal written here gets a default first, so no path leaves a
      // value held and no latch is inferred.
      w_jal  = '0;
      w_jalr = '0;
      w_br   = '0;
      for (int i = 0; i < INST_NUM; i++) begin
         inst = r_data[i*32 +: 32];
         pc   = r_start_addr + (VADDR_W'(i) << 2);
         jimm = {{(VADDR_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         push = (inst[11:7] == 5'd1) || (inst[11:7] == 5'd5);
         pop  = (inst[19:15] == 5'd1) || (inst[19:15] == 5'd5);

         w_jal[i]  = (inst[6:0] == OP_JAL);
         w_jalr[i] = (inst[6:0] == OP_JALR);
         w_br[i]   = (inst[6:0] == OP_BRANCH);
         w_tgt[i]  = pc + jimm;

         if (w_jal[i]) begin
            w_br_type[i] = BR_DIRECT;
         end else if (w_jalr[i]) begin
            w_br_type[i] = (push || pop) ? BR_CALL : BR_INDIRECT;
         end else begin
            w_br_type[i] = BR_CONDITION;
         end

         if (w_jal[i]) begin
            w_ras[i] = push ? RAS_PUSH : RAS_NONE;
         end else if (w_jalr[i]) begin
            if (push && pop)  w_ras[i] = RAS_POP_PUSH;
            else if (push)    w_ras[i] = RAS_PUSH;
            else if (pop)     w_ras[i] = RAS_POP;
            else              w_ras[i] = RAS_NONE;
         end else begin
            w_ras[i] = RAS_NONE;
         end
      end
   end

   // Only enabled jal slots can redirect: their target is fully known here
   assign w_jmp     = r_en & w_jal;
   assign w_any_jmp = |w_jmp;

   // Priority encoder: lowest enabled jal wins
   always_comb begin
      w_sel = '0;
      for (int i = INST_NUM - 1; i >= 0; i--) begin
         if (w_jmp[i]) w_sel = SW'(i);
      end
   end

`ifdef PREDECODE_FALSEHIT_EN
   assign w_tail_is_cfi = r_en[r_tail] && (w_jal[r_tail] || w_jalr[r_tail] || w_br[r_tail]);
   assign w_fall_addr   = r_start_addr + (VADDR_W'({1'b0, r_tail} + (SW+1)'(1)) << 2);
`endif

   // Mispredict detection against the FSQ prediction, first matching case wins
   always_comb begin
      w_mis         = 1'b0;
      w_off         = '0;
      w_addr        = '0;
      w_rd_br_type  = BR_CONDITION;
      w_rd_ras_type = RAS_NONE;
      if (!r_taken && w_any_jmp) begin
         // unpredicted jal
         w_mis         = 1'b1;
         w_off         = w_sel;
         w_addr        = w_tgt[w_sel];
         w_rd_br_type  = w_br_type[w_sel];
         w_rd_ras_type = w_ras[w_sel];
      end else if (r_taken && w_any_jmp && (w_sel < r_tail)) begin
         // jal ahead of the predicted taken slot
         w_mis         = 1'b1;
         w_off         = w_sel;
         w_addr        = w_tgt[w_sel];
         w_rd_br_type  = w_br_type[w_sel];
         w_rd_ras_type = w_ras[w_sel];
      end else if (r_taken && w_jmp[r_tail] && (w_tgt[r_tail] != r_target)) begin
         // right slot, wrong target
         w_mis         = 1'b1;
         w_off         = r_tail;
         w_addr        = w_tgt[r_tail];
         w_rd_br_type  = w_br_type[r_tail];
         w_rd_ras_type = w_ras[r_tail];
`ifdef PREDECODE_FALSEHIT_EN
      end else if (r_taken && !w_tail_is_cfi) begin
         // predictor hit on a slot that cannot jump: fall through after the tail
         w_mis         = 1'b1;
         w_off         = r_tail;
         w_addr        = w_fall_addr;
         w_rd_br_type  = BR_CONDITION;
         w_rd_ras_type = RAS_NONE;
`else
      end else begin
         // false-hit check not built: such blocks pass unmodified
         w_mis = 1'b0;
`endif
      end
   end

   // Forward mask truncated after the redirecting slot, and its population count
   always_comb begin
      w_out_en  = r_en;
      w_out_num = '0;
      for (int i = 0; i < INST_NUM; i++) begin
         if (w_mis && (SW'(i) > w_off)) w_out_en[i] = 1'b0;
         w_out_num = w_out_num + (SW+1)'(w_out_en[i]);
      end
   end

   assign o_in_ready    = w_in_ready;
   assign o_out_valid   = r_valid;
   assign o_out_en      = w_out_en;
   assign o_out_inst    = r_data;
   assign o_out_num     = w_out_num;
   assign o_out_fsq_idx = r_fsq_idx;

   assign o_rd_valid    = w_fire && w_mis && !i_flush;
   assign o_rd_fsq_idx  = r_fsq_idx;
   assign o_rd_offset   = w_off;
   assign o_rd_pc       = r_start_addr;
   assign o_rd_addr     = w_addr;
   assign o_rd_br_type  = w_rd_br_type;
   assign o_rd_ras_type = w_rd_ras_type;

endmodule

// File: tb/tb_predecode_pipe.sv
// tb_predecode_pipe: vector table plus scoreboard for predecode_pipe, with hand-written
// stall and flush sequences. Honours PREDECODE_FALSEHIT_EN for the false-hit vector.

module tb_predecode_pipe;
   import predecode_pkg::*;

   localparam int INST_NUM = 8;
   localparam int VADDR_W  = 32;
   localparam int FSQ_W    = 5;
   localparam int SW       = 3;
   localparam int NVEC     = 11;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] JALR = 32'h0000_80E7;   // jalr x1, 0(x1)
   localparam logic [31:0] BEQ  = 32'h0000_0463;   // beq x0, x0, +8

   typedef struct {
      logic [7:0]   en;
      logic [255:0] data;
      logic [31:0]  pc;
      logic [2:0]   tail;
      logic         taken;
      logic [31:0]  target;
      logic [4:0]   fsq;
      logic         mis;
      logic [2:0]   off;
      logic [31:0]  addr;
      branch_type_e br;
      ras_type_e    ras;
      logic [7:0]   oen;
      logic [3:0]   onum;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   i_flush;
   logic                   i_in_valid;
   logic                   o_in_ready;
   logic [INST_NUM-1:0]    i_in_en;
   logic [INST_NUM*32-1:0] i_in_data;
   logic [VADDR_W-1:0]     i_in_start_addr;
   logic [SW-1:0]          i_in_tail;
   logic                   i_in_taken;
   logic [VADDR_W-1:0]     i_in_target;
   logic [FSQ_W-1:0]       i_in_fsq_idx;
   logic                   o_out_valid;
   logic                   i_out_ready;
   logic [INST_NUM-1:0]    o_out_en;
   logic [INST_NUM*32-1:0] o_out_inst;
   logic [SW:0]            o_out_num;
   logic [FSQ_W-1:0]       o_out_fsq_idx;
   logic                   o_rd_valid;
   logic [FSQ_W-1:0]       o_rd_fsq_idx;
   logic [SW-1:0]          o_rd_offset;
   logic [VADDR_W-1:0]     o_rd_pc;
   logic [VADDR_W-1:0]     o_rd_addr;
   branch_type_e           o_rd_br_type;
   ras_type_e              o_rd_ras_type;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs [NVEC];
   vec_t sb [$];

   predecode_pipe #(.INST_NUM(INST_NUM), .VADDR_W(VADDR_W), .FSQ_W(FSQ_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_flush         (i_flush),
      .i_in_valid      (i_in_valid),
      .o_in_ready      (o_in_ready),
      .i_in_en         (i_in_en),
      .i_in_data       (i_in_data),
      .i_in_start_addr (i_in_start_addr),
      .i_in_tail       (i_in_tail),
      .i_in_taken      (i_in_taken),
      .i_in_target     (i_in_target),
      .i_in_fsq_idx    (i_in_fsq_idx),
      .o_out_valid     (o_out_valid),
      .i_out_ready     (i_out_ready),
      .o_out_en        (o_out_en),
      .o_out_inst      (o_out_inst),
      .o_out_num       (o_out_num),
      .o_out_fsq_idx   (o_out_fsq_idx),
      .o_rd_valid      (o_rd_valid),
      .o_rd_fsq_idx    (o_rd_fsq_idx),
      .o_rd_offset     (o_rd_offset),
      .o_rd_pc         (o_rd_pc),
      .o_rd_addr       (o_rd_addr),
      .o_rd_br_type    (o_rd_br_type),
      .o_rd_ras_type   (o_rd_ras_type)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] jal_enc(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic vec_t mkv(input logic [31:0] pc, input logic [7:0] en,
                                input logic [2:0] tail, input logic taken,
                                input logic [31:0] target, input logic mis,
                                input logic [2:0] off, input logic [31:0] addr,
                                input branch_type_e br, input ras_type_e ras,
                                input logic [7:0] oen, input logic [3:0] onum);
      vec_t v;
      v.en = en;   v.data = {8{NOP}}; v.pc = pc;     v.tail = tail;
      v.taken = taken; v.target = target; v.fsq = '0;
      v.mis = mis; v.off = off; v.addr = addr; v.br = br; v.ras = ras;
      v.oen = oen; v.onum = onum;
      return v;
   endfunction

   // Drive one block and hold it until the stage accepts it; expectations enter the scoreboard
   task automatic send(input vec_t v, input logic [4:0] fsq);
      logic acc;
      vec_t e;
      i_in_en = v.en; i_in_data = v.data; i_in_start_addr = v.pc; i_in_tail = v.tail;
      i_in_taken = v.taken; i_in_target = v.target; i_in_fsq_idx = fsq;
      i_in_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = o_in_ready;
         @(posedge clk);
      end
      if (acc) begin
         e = v;
         e.fsq = fsq;
         sb.push_back(e);
      end else begin
         check("send_timeout", 0, 1);
      end
      #1 i_in_valid = 1'b0;
   endtask

   // Output monitor: every delivered block is compared with the oldest expectation
   always @(negedge clk) begin
      vec_t e;
      if (!rst && o_out_valid && i_out_ready && !i_flush) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            check("out_en",   o_out_en,      e.oen);
            check("out_num",  o_out_num,     e.onum);
            check("out_inst", o_out_inst,    e.data);
            check("out_fsq",  o_out_fsq_idx, e.fsq);
            check("rd_valid", o_rd_valid,    e.mis);
            if (e.mis) begin
               check("rd_offset",   o_rd_offset,   e.off);
               check("rd_addr",     o_rd_addr,     e.addr);
               check("rd_pc",       o_rd_pc,       e.pc);
               check("rd_fsq",      o_rd_fsq_idx,  e.fsq);
               check("rd_br_type",  o_rd_br_type,  e.br);
               check("rd_ras_type", o_rd_ras_type, e.ras);
            end
         end
      end
      if (!rst && o_rd_valid && !(o_out_valid && i_out_ready)) check("rd_without_fire", 1, 0);
   end

   initial begin
      // Vector table: expected values worked out by hand from the instruction encodings
      vecs[0] = mkv(32'h1000, 8'hFF, 3'd7, 1'b0, 32'h0, 1'b1, 3'd2, 32'h1048,
                    BR_DIRECT, RAS_NONE, 8'h07, 4'd3);
      vecs[0].data[2*32 +: 32] = jal_enc(5'd0, 21'h40);
      vecs[1] = mkv(32'h1000, 8'hFF, 3'd5, 1'b1, 32'h2000, 1'b0, 3'd0, 32'h0,
                    BR_CONDITION, RAS_NONE, 8'hFF, 4'd8);
      vecs[1].data[5*32 +: 32] = jal_enc(5'd1, 21'hFEC);
      vecs[2] = mkv(32'h1000, 8'hFF, 3'd5, 1'b1, 32'h2000, 1'b1, 3'd5, 32'h1100,
                    BR_DIRECT, RAS_PUSH, 8'h3F, 4'd6);
      vecs[2].data[5*32 +: 32] = jal_enc(5'd1, 21'hEC);
      vecs[3] = mkv(32'h3000, 8'hFF, 3'd6, 1'b1, 32'h3028, 1'b1, 3'd1, 32'h3104,
                    BR_DIRECT, RAS_NONE, 8'h03, 4'd2);
      vecs[3].data[1*32 +: 32] = jal_enc(5'd0, 21'h100);
      vecs[3].data[6*32 +: 32] = jal_enc(5'd0, 21'h10);
      vecs[4] = mkv(32'h1000, 8'h00, 3'd7, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0,
                    BR_CONDITION, RAS_NONE, 8'h00, 4'd0);
      vecs[4].data[0 +: 32] = jal_enc(5'd0, 21'h40);
      vecs[5] = mkv(32'h4000, 8'h0F, 3'd7, 1'b0, 32'h0, 1'b1, 3'd0, 32'h3F00,
                    BR_DIRECT, RAS_PUSH, 8'h01, 4'd1);
      vecs[5].data[0 +: 32] = jal_enc(5'd5, 21'h1FFF00);
      vecs[6] = mkv(32'h4F00, 8'hFF, 3'd7, 1'b1, 32'h5000, 1'b0, 3'd0, 32'h0,
                    BR_CONDITION, RAS_NONE, 8'hFF, 4'd8);
      vecs[6].data[2*32 +: 32] = JALR;
      vecs[6].data[3*32 +: 32] = BEQ;
      vecs[6].data[7*32 +: 32] = jal_enc(5'd0, 21'hE4);
      vecs[7] = mkv(32'h1000, 8'hFB, 3'd7, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0,
                    BR_CONDITION, RAS_NONE, 8'hFB, 4'd7);
      vecs[7].data[2*32 +: 32] = jal_enc(5'd0, 21'h40);
      vecs[8] = vecs[6];
      vecs[8].target = 32'h6000; vecs[8].mis = 1'b1; vecs[8].off = 3'd7;
      vecs[8].addr = 32'h5000; vecs[8].br = BR_DIRECT;
`ifdef PREDECODE_FALSEHIT_EN
      vecs[9] = mkv(32'h1000, 8'hFF, 3'd3, 1'b1, 32'h2000, 1'b1, 3'd3, 32'h1010,
                    BR_CONDITION, RAS_NONE, 8'h0F, 4'd4);
`else
      vecs[9] = mkv(32'h1000, 8'hFF, 3'd3, 1'b1, 32'h2000, 1'b0, 3'd0, 32'h0,
                    BR_CONDITION, RAS_NONE, 8'hFF, 4'd8);
`endif
      vecs[10] = mkv(32'hFFFF_FFF0, 8'hFF, 3'd7, 1'b0, 32'h0, 1'b1, 3'd0, 32'h10,
                     BR_DIRECT, RAS_NONE, 8'h01, 4'd1);
      vecs[10].data[0 +: 32] = jal_enc(5'd0, 21'h20);

      // Reset
      rst = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
      i_in_en = '0; i_in_data = '0; i_in_start_addr = '0; i_in_tail = '0;
      i_in_taken = 1'b0; i_in_target = '0; i_in_fsq_idx = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_rd_valid",  o_rd_valid,  0);
      check("rst_out_num",   o_out_num,   0);
      check("rst_out_en",    o_out_en,    0);
      check("rst_out_inst",  o_out_inst,  0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", o_in_ready, 1);
      @(posedge clk);
      #1;

      // Table: back-to-back blocks, monitor compares them as they leave
      for (int i = 0; i < NVEC; i++) send(vecs[i], 5'(i));
      for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
      check("table_drained", 32'(sb.size()), 0);
      #1;

      // Stall: a held mispredicting block never pulses, then pulses exactly once
      i_out_ready = 1'b0;
      send(vecs[0], 5'd20);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_rd_valid",  o_rd_valid,  0);
         check("stall_in_ready",  o_in_ready,  0);
         check("stall_out_valid", o_out_valid, 1);
      end
      @(posedge clk);
      #1 i_out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_rd_valid", o_rd_valid, 1);
      check("stall_release_in_ready", o_in_ready, 0);
      @(negedge clk);
      check("stall_single_pulse", o_rd_valid,  0);
      check("stall_emptied",      o_out_valid, 0);
      @(posedge clk);
      #1;

      // Flush: held mispredicting block dropped, offered block not loaded
      i_out_ready = 1'b0;
      send(vecs[0], 5'd21);
      i_in_en = vecs[1].en; i_in_data = vecs[1].data; i_in_start_addr = vecs[1].pc;
      i_in_tail = vecs[1].tail; i_in_taken = vecs[1].taken; i_in_target = vecs[1].target;
      i_in_fsq_idx = 5'd22;
      i_in_valid = 1'b1; i_flush = 1'b1; i_out_ready = 1'b1;
      @(negedge clk);
      check("flush_rd_valid", o_rd_valid, 0);
      check("flush_in_ready", o_in_ready, 0);
      @(posedge clk);
      #1 i_flush = 1'b0; i_in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_dropped",    o_out_valid, 0);
      check("flush_no_rd",      o_rd_valid,  0);
      check("flush_in_ready_1", o_in_ready,  1);

      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
